// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch path.
//   WORD_W    : instruction/address word width
//   HALT_WORD : instruction word that stops fetching
//   PC_STEP   : PC increment per fetched word
//   fetch_state_t : fetch FSM states
package mips_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   push, push_data     : write request and data
//   pop                 : read request (advances head)
//   flush               : empty the FIFO (highest priority)
//   head_data           : data at head (registered storage)
//   full, empty, count  : occupancy status
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty     = (cnt == '0);
  assign full      = (cnt == (AW+1)'(DEPTH));
  assign count     = cnt;
  assign head_data = mem[rd_ptr];

  // Simultaneous push+pop on a full FIFO is allowed: the pop frees the slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch unit: owns the PC, issues single-outstanding word
// reads to instruction memory, buffers {pc, instruction} for decode, handles
// redirects (flush + restart) and stops on the all-zero halt word.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   imem_req, imem_addr            : request strobe / word byte address (comb)
//   imem_rvalid, imem_rdata        : memory response
//   inst_valid, inst_data, inst_pc : buffer head to decode
//   inst_ready                     : decode accepts head
//   redirect_valid, redirect_pc    : flush and restart fetch at new PC
//   halted                         : halt word fetched, fetching stopped
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t state_q, state_d;

  logic [31:0]   fetch_pc_q;
  logic [31:0]   req_pc_q;
  logic          outstanding_q;
  logic          discard_q;

  logic [63:0]   fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occ_next;

  logic resp_live, resp_take, halt_seen, push, pop, slot_free, issue;

  // A response only counts when it belongs to our outstanding request and
  // is not overridden by a redirect in the same cycle.
  assign resp_live = imem_rvalid && outstanding_q && !redirect_valid;
  assign resp_take = resp_live && !discard_q;
  assign halt_seen = resp_take && (imem_rdata == HALT_WORD);
  assign push      = resp_take && !halt_seen;
  assign pop       = !fifo_empty && inst_ready && !redirect_valid;
  assign occ_next  = fifo_count + CW'(push) - CW'(pop);
  assign slot_free = !outstanding_q || imem_rvalid;

  // Halt response blocks the issue in its own cycle so no request is ever
  // outstanding once in HALT.
  assign issue = !reset && (state_q == RUN) && !redirect_valid && slot_free &&
                 !halt_seen && (occ_next < CW'(FIFO_DEPTH));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (redirect_valid)  state_d = RUN;
    else if (halt_seen)  state_d = HALT;
  end

  // Output logic
  always_comb begin
    halted    = (state_q == HALT);
    imem_req  = issue;
    imem_addr = fetch_pc_q;
  end

  // PC and request tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_q    <= {redirect_pc[31:2], 2'b00};
      outstanding_q <= outstanding_q && !imem_rvalid;
      discard_q     <= outstanding_q && !imem_rvalid;
    end else begin
      if (issue) begin
        fetch_pc_q    <= fetch_pc_q + PC_STEP;
        req_pc_q      <= fetch_pc_q;
        outstanding_q <= 1'b1;
      end else if (imem_rvalid) begin
        outstanding_q <= 1'b0;
      end
      if (imem_rvalid && outstanding_q) begin
        discard_q <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({req_pc_q, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign inst_valid = !fifo_empty;
  assign inst_pc    = fifo_head[63:32];
  assign inst_data  = fifo_head[31:0];

  // The issue rule must never let a response land in a full buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && fifo_full && !pop));
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } deliv_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        chk_head;
    logic [31:0] e_pc;
    logic [31:0] e_data;
    logic        e_halted;
  } vec_t;

  logic [31:0] memw [64];
  pend_t       pend[$];
  deliv_t      dq[$];
  int          cyc = 0;
  int          lat = 1;
  int          nchk = 0;
  int          nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fill_default();
    for (int i = 0; i < 64; i++) memw[i] = 32'hA000_0000 | (i * 4);
  endtask

  // Drive this cycle's inputs and memory response, then let logic settle.
  task automatic begin_cycle(input logic r, input logic rdy, input logic rv,
                             input logic [31:0] rpc);
    reset          = r;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memw[pend[0].addr[7:2]];
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
  endtask

  task automatic end_cycle();
    if (imem_req) pend.push_back('{imem_addr, cyc + lat});
    if (inst_valid && inst_ready && !redirect_valid && !reset)
      dq.push_back('{inst_pc, inst_data});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int l);
    lat = l;
    for (int i = 0; i < 4; i++) begin
      begin_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      end_cycle();
    end
    pend.delete();
    dq.delete();
  endtask

  vec_t tbl[7];

  initial begin
    logic        found;
    logic        got;
    logic [31:0] first_addr;
    int          nreq;

    reset = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);

    // ---- 1-cycle memory, halt program, table-driven ----
    fill_default();
    memw[0] = 32'h2008_0005;
    memw[1] = 32'h2009_0003;
    memw[2] = 32'h0000_0000;
    lat = 1;
    begin_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    end_cycle();
    pend.delete();
    dq.delete();
    //        rst  rdy  req  addr      valid head pc     data           halted
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0,          1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,          1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0,          1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 32'h0, 32'h2008_0005,  1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'hC, 1'b1, 1'b1, 32'h4, 32'h2009_0003,  1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0,          1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0,          1'b1};
    for (int i = 0; i < 7; i++) begin
      begin_cycle(tbl[i].rst, tbl[i].rdy, 1'b0, 32'h0);
      chk($sformatf("t1[%0d].imem_req", i),   32'(imem_req),   32'(tbl[i].e_req));
      chk($sformatf("t1[%0d].imem_addr", i),  imem_addr,       tbl[i].e_addr);
      chk($sformatf("t1[%0d].inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
      chk($sformatf("t1[%0d].halted", i),     32'(halted),     32'(tbl[i].e_halted));
      if (tbl[i].chk_head) begin
        chk($sformatf("t1[%0d].inst_pc", i),   inst_pc,   tbl[i].e_pc);
        chk($sformatf("t1[%0d].inst_data", i), inst_data, tbl[i].e_data);
      end
      end_cycle();
    end
    chk("t1.delivered_count", 32'(dq.size()), 32'd2);

    // ---- redirect out of HALT to 0 ----
    begin_cycle(1'b0, 1'b1, 1'b1, 32'h0);
    chk("t5.halted_before", 32'(halted), 32'd1);
    chk("t5.req_in_redirect", 32'(imem_req), 32'd0);
    end_cycle();
    begin_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5.halted_after", 32'(halted), 32'd0);
    chk("t5.req_restart", 32'(imem_req), 32'd1);
    chk("t5.addr_restart", imem_addr, 32'h0);
    end_cycle();

    // ---- 3-cycle memory, decode stalled, then resumes ----
    fill_default();
    do_reset(3);
    nreq = 0;
    for (int i = 0; i < 15; i++) begin
      begin_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      if (imem_req) nreq++;
      end_cycle();
    end
    chk("t2.stall_requests", 32'(nreq), 32'd2);
    begin_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t2.stall_req_low", 32'(imem_req), 32'd0);
    chk("t2.stall_valid", 32'(inst_valid), 32'd1);
    chk("t2.stall_head_pc", inst_pc, 32'h0);
    end_cycle();
    for (int i = 0; i < 30; i++) begin
      begin_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      end_cycle();
    end
    chk("t2.enough_delivered", 32'(dq.size() >= 6), 32'd1);
    if (dq.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t2.pc[%0d]", i),   dq[i].pc,   32'(i * 4));
        chk($sformatf("t2.data[%0d]", i), dq[i].data, memw[i]);
      end
    end

    // ---- redirect to 0x43 while 0x10 is outstanding ----
    do_reset(3);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      begin_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (imem_req && imem_addr == 32'h10) found = 1'b1;
      end_cycle();
    end
    chk("t3.found_req_0x10", 32'(found), 32'd1);
    begin_cycle(1'b0, 1'b1, 1'b1, 32'h43);
    chk("t3.req_in_redirect", 32'(imem_req), 32'd0);
    end_cycle();
    dq.delete();
    got = 1'b0;
    first_addr = '0;
    for (int i = 0; i < 20; i++) begin
      begin_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (i == 0) chk("t3.valid_after_redirect", 32'(inst_valid), 32'd0);
      if (imem_req && !got) begin
        got = 1'b1;
        first_addr = imem_addr;
      end
      end_cycle();
    end
    chk("t3.req_after_redirect", 32'(got), 32'd1);
    chk("t3.first_addr", first_addr, 32'h40);
    chk("t3.delivered_any", 32'(dq.size() > 0), 32'd1);
    if (dq.size() > 0) begin
      chk("t3.first_pc", dq[0].pc, 32'h40);
      chk("t3.first_data", dq[0].data, memw[16]);
    end

    // ---- redirect coinciding with rvalid and pop ----
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      begin_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      end_cycle();
    end
    begin_cycle(1'b0, 1'b1, 1'b1, 32'h80);
    chk("t4.valid_pre", 32'(inst_valid), 32'd1);
    chk("t4.req_in_redirect", 32'(imem_req), 32'd0);
    end_cycle();
    begin_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t4.valid_next", 32'(inst_valid), 32'd0);
    chk("t4.req_next", 32'(imem_req), 32'd1);
    chk("t4.addr_next", imem_addr, 32'h80);
    end_cycle();
    begin_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t4.valid_fill", 32'(inst_valid), 32'd0);
    end_cycle();
    begin_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t4.valid_first", 32'(inst_valid), 32'd1);
    chk("t4.pc_first", inst_pc, 32'h80);
    chk("t4.data_first", inst_data, memw[32]);
    end_cycle();

    // ---- reset mid-stream with a request outstanding ----
    do_reset(3);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      begin_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
      end_cycle();
    end
    chk("t6.found_req_0x8", 32'(found), 32'd1);
    begin_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    end_cycle();
    begin_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6.rst_req", 32'(imem_req), 32'd0);
    chk("t6.rst_addr", imem_addr, 32'h0);
    chk("t6.rst_valid", 32'(inst_valid), 32'd0);
    chk("t6.rst_pc", inst_pc, 32'h0);
    chk("t6.rst_data", inst_data, 32'h0);
    chk("t6.rst_halted", 32'(halted), 32'd0);
    end_cycle();
    dq.delete();
    begin_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t6.first_req", 32'(imem_req), 32'd1);
    chk("t6.first_addr", imem_addr, 32'h0);
    end_cycle();
    for (int i = 0; i < 12; i++) begin
      begin_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      end_cycle();
    end
    chk("t6.delivered_two", 32'(dq.size() >= 2), 32'd1);
    if (dq.size() >= 2) begin
      chk("t6.pc0", dq[0].pc, 32'h0);
      chk("t6.data0", dq[0].data, memw[0]);
      chk("t6.pc1", dq[1].pc, 32'h4);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
